// File: rtl/score_pkg.sv
// Shared constants and FSM state type for the score renderer.
//   GLYPH_W / GLYPH_H : glyph cell size in pixels (one ROM row = GLYPH_W bits)
//   state_e           : renderer FSM states
package score_pkg;

  localparam int unsigned GLYPH_W = 16;
  localparam int unsigned GLYPH_H = 16;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StWaitX,
    StDraw
  } state_e;

endpackage

// File: rtl/score_renderer.sv
// Scanline renderer for a BCD score field drawn with an external glyph ROM.
// The score is sampled once per frame. It is then rendered row by row. At
// each qualifying scanline the ROM rows of all digits are prefetched into a
// row buffer. The buffer is then shifted out as pixels across the field.
//
// Ports:
//   clk, rst_n        : system clock, async active-low reset
//   pix_en            : pixel-rate strobe
//   hcount, vcount    : current pixel column / row
//   line_start        : start-of-scanline pulse (horizontal blanking)
//   score_bcd         : BCD score, digit 0 (most significant) in top nibble
//   rom_digit/rom_line: glyph ROM address, zero outside prefetch
//   rom_data          : glyph ROM row, bit 15 = leftmost pixel
//   pixel_on          : registered score pixel
//   busy              : prefetching or drawing
module score_renderer
  import score_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned X0     = 16,
  parameter int unsigned Y0     = 8,
  parameter bit          LZB    = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pix_en,
  input  logic [9:0]          hcount,
  input  logic [9:0]          vcount,
  input  logic                line_start,
  input  logic [4*DIGITS-1:0] score_bcd,
  output logic [3:0]          rom_digit,
  output logic [3:0]          rom_line,
  input  logic [15:0]         rom_data,
  output logic                pixel_on,
  output logic                busy
);

  localparam int unsigned     IdxW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [9:0]      XStart  = 10'(X0);
  localparam logic [9:0]      YFirst  = 10'(Y0);
  localparam logic [9:0]      YLast   = 10'(Y0 + GLYPH_H - 1);
  localparam logic [9:0]      DrawW   = 10'(GLYPH_W * DIGITS);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  state_e          state_q, state_d;
  logic [3:0]      frame_q [DIGITS];
  logic [3:0]      frame_d [DIGITS];
  logic [15:0]     slot_q  [DIGITS];
  logic [15:0]     slot_d  [DIGITS];
  logic [IdxW-1:0] idx_q, idx_d;
  logic [3:0]      line_q, line_d;
  logic            lead_zero_q, lead_zero_d;  // all digits fetched so far were 0
  logic            miss_q, miss_d;            // field start passed during prefetch
  logic            pixel_q, pixel_d;

  logic            in_window;
  logic            at_x0;
  logic            blank_slot;
  logic [9:0]      hoff;
  logic [IdxW-1:0] draw_sel;
  logic [3:0]      cur_digit;

  assign in_window = (vcount >= YFirst) && (vcount <= YLast);
  assign at_x0     = pix_en && (hcount == XStart);
  // Offset from the field start; values below X0 wrap high and read as out of field.
  assign hoff      = hcount - XStart;
  assign draw_sel  = hoff[4 +: IdxW];
  assign cur_digit = frame_q[idx_q];
  // The last digit is never blanked, so a zero score still shows "0".
  assign blank_slot = LZB && lead_zero_q && (cur_digit == 4'd0) && (idx_q != LastIdx);

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    slot_d      = slot_q;
    idx_d       = idx_q;
    line_d      = line_q;
    lead_zero_d = lead_zero_q;
    miss_d      = miss_q;
    pixel_d     = pixel_q;
    rom_digit   = 4'd0;
    rom_line    = 4'd0;

    if (state_q == StFetch) begin
      rom_digit = cur_digit;
      rom_line  = line_q;
    end

    // line_start overrides any pixel progression in the same cycle.
    if (line_start) begin
      if (vcount == 10'd0) begin
        for (int i = 0; i < int'(DIGITS); i++) begin
          frame_d[i] = score_bcd[4*(int'(DIGITS)-1-i) +: 4];
        end
      end
      idx_d       = '0;
      line_d      = vcount[3:0] - YFirst[3:0];
      lead_zero_d = 1'b1;
      miss_d      = 1'b0;
      pixel_d     = 1'b0;
      state_d     = in_window ? StFetch : StIdle;
    end else begin
      unique case (state_q)
        StFetch: begin
          slot_d[idx_q] = blank_slot ? 16'h0000 : rom_data;
          lead_zero_d   = lead_zero_q && (cur_digit == 4'd0);
          idx_d         = idx_q + 1'b1;
          if (at_x0) miss_d = 1'b1;
          if (idx_q == LastIdx) state_d = (miss_q || at_x0) ? StIdle : StWaitX;
        end
        StWaitX: begin
          if (at_x0) begin
            state_d = StDraw;
            pixel_d = slot_q[0][GLYPH_W-1];
          end
        end
        StDraw: begin
          if (pix_en) begin
            if (hoff < DrawW) begin
              pixel_d = slot_q[draw_sel][~hoff[3:0]];
            end else begin
              pixel_d = 1'b0;
              state_d = StIdle;
            end
          end
        end
        default: begin
          pixel_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      line_q      <= 4'd0;
      lead_zero_q <= 1'b1;
      miss_q      <= 1'b0;
      pixel_q     <= 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
        frame_q[i] <= 4'd0;
        slot_q[i]  <= 16'h0000;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      line_q      <= line_d;
      lead_zero_q <= lead_zero_d;
      miss_q      <= miss_d;
      pixel_q     <= pixel_d;
      frame_q     <= frame_d;
      slot_q      <= slot_d;
    end
  end

  assign pixel_on = pixel_q;
  assign busy     = (state_q == StFetch) || (state_q == StDraw);

endmodule

// File: tb/tb_score_renderer.sv
// Self-checking bench for score_renderer (DIGITS=4, X0=16, Y0=8, LZB=1).
// A behavioural glyph ROM feeds the DUT. Expected pixels come from a per-column
// model: the frame value, the leading-zero rule and the glyph bit at that column.
module tb_score_renderer;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b0;
  logic        pix_en     = 1'b0;
  logic        line_start = 1'b0;
  logic [9:0]  hcount     = 10'd0;
  logic [9:0]  vcount     = 10'd0;
  logic [15:0] score_bcd  = 16'h0000;
  logic [3:0]  rom_digit;
  logic [3:0]  rom_line;
  logic [15:0] rom_data;
  logic        pixel_on;
  logic        busy;

  bit          rom_mode    = 1'b0;
  logic [15:0] model_frame = 16'h0000;
  int          n_checks    = 0;
  int          n_errors    = 0;

  always #5 clk = ~clk;

  score_renderer #(
    .DIGITS(4),
    .X0    (16),
    .Y0    (8),
    .LZB   (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_en    (pix_en),
    .hcount    (hcount),
    .vcount    (vcount),
    .line_start(line_start),
    .score_bcd (score_bcd),
    .rom_digit (rom_digit),
    .rom_line  (rom_line),
    .rom_data  (rom_data),
    .pixel_on  (pixel_on),
    .busy      (busy)
  );

  // Glyph ROM: mode 1 gives a fixed 0x3FFC row; digits above 9 are blank.
  function automatic logic [15:0] glyph(bit mode, int d, int l);
    if (d > 9) return 16'h0000;
    if (mode) return 16'h3FFC;
    return 16'(((d + 1) * 40503) ^ (l * 4681) ^ (l << 12) ^ 32'h8001);
  endfunction

  always_comb rom_data = glyph(rom_mode, int'(rom_digit), int'(rom_line));

  function automatic int nib(logic [15:0] f, int i);
    return int'((f >> (4 * (3 - i))) & 16'h000F);
  endfunction

  function automatic bit in_win(int vc);
    return (vc >= 8) && (vc <= 23);
  endfunction

  function automatic logic exp_pix(logic [15:0] f, int vc, int hc, bit mode);
    int          k;
    int          j;
    int          first;
    logic [15:0] row;
    if (!in_win(vc) || hc < 16 || hc > 79) return 1'b0;
    k     = hc - 16;
    j     = k / 16;
    first = 3;
    for (int i = 3; i >= 0; i--) if (nib(f, i) != 0) first = i;
    row = (j >= first) ? glyph(mode, nib(f, j), vc - 8) : 16'h0000;
    return row[15 - (k % 16)];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One scanline: line_start (with a coincident pixel strobe), prefetch, then sweep.
  task automatic do_line(int vc, int stop_hc);
    logic e;
    line_start = 1'b1;
    vcount     = 10'(vc);
    pix_en     = 1'b1;
    hcount     = 10'd16;
    tick();
    line_start = 1'b0;
    pix_en     = 1'b0;
    if (vc == 0) model_frame = score_bcd;
    check("ls_pixel", pixel_on, 0);
    if (in_win(vc)) begin
      for (int i = 0; i < 4; i++) begin
        check("fetch_busy", busy, 1);
        check("rom_digit", rom_digit, nib(model_frame, i));
        check("rom_line", rom_line, (vc - 8) & 15);
        tick();
      end
      check("wait_busy", busy, 0);
    end else begin
      check("idle_busy", busy, 0);
      check("idle_rom", {rom_digit, rom_line}, 0);
      repeat (4) tick();
    end
    check("idle_rom_after", {rom_digit, rom_line}, 0);
    for (int hc = 0; hc <= stop_hc; hc++) begin
      hcount = 10'(hc);
      pix_en = 1'b1;
      tick();
      pix_en = 1'b0;
      e = exp_pix(model_frame, vc, hc, rom_mode);
      check("pixel", pixel_on, e);
      check("draw_busy", busy, in_win(vc) && hc >= 16 && hc <= 79);
      tick();
      check("pixel_hold", pixel_on, e);
    end
  endtask

  // Field start arrives while the prefetch is still running: line must stay blank.
  task automatic miss_line(int vc);
    line_start = 1'b1;
    vcount     = 10'(vc);
    tick();
    line_start = 1'b0;
    pix_en     = 1'b1;
    hcount     = 10'd16;
    tick();
    pix_en = 1'b0;
    repeat (3) tick();
    check("miss_busy", busy, 0);
    for (int hc = 17; hc <= 85; hc++) begin
      hcount = 10'(hc);
      pix_en = 1'b1;
      tick();
      pix_en = 1'b0;
      check("miss_pixel", pixel_on, 0);
    end
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_pixel", pixel_on, 0);
    check("rst_busy", busy, 0);
    check("rst_rom", {rom_digit, rom_line}, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", busy, 0);

    // Fetch sequence and hashed glyphs
    score_bcd = 16'h1234;
    do_line(0, 99);
    do_line(10, 99);
    // Fixed 0x3FFC rows
    rom_mode = 1'b1;
    do_line(9, 99);
    rom_mode = 1'b0;

    // Leading-zero blanking
    score_bcd = 16'h0070;
    do_line(0, 99);
    do_line(12, 99);
    score_bcd = 16'h0000;
    do_line(0, 99);
    do_line(8, 99);
    do_line(23, 99);

    // Frame copy isolates mid-frame score updates; nibbles above 9 render blank
    score_bcd = 16'h5678;
    do_line(0, 99);
    do_line(11, 99);
    score_bcd = 16'h9AF1;
    do_line(12, 99);
    do_line(0, 99);
    do_line(13, 99);

    // Lines outside the field
    do_line(7, 99);
    do_line(24, 99);

    // Prefetch overrun
    miss_line(10);

    // line_start mid-draw restarts the prefetch
    do_line(14, 40);
    do_line(15, 99);

    // Reset at draw pixel k=20
    score_bcd = 16'h4321;
    do_line(0, 99);
    do_line(10, 36);
    rst_n = 1'b0;
    #1;
    check("abort_pixel", pixel_on, 0);
    check("abort_busy", busy, 0);
    check("abort_rom", {rom_digit, rom_line}, 0);
    model_frame = 16'h0000;
    tick();
    rst_n = 1'b1;
    for (int hc = 37; hc <= 60; hc++) begin
      hcount = 10'(hc);
      pix_en = 1'b1;
      tick();
      pix_en = 1'b0;
      check("post_abort_pixel", pixel_on, 0);
      check("post_abort_busy", busy, 0);
    end
    do_line(10, 99);
    do_line(0, 99);
    do_line(10, 99);

    // Randomized frames and lines
    for (int n = 0; n < 12; n++) begin
      logic [15:0] s;
      for (int i = 0; i < 4; i++) begin
        s[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      end
      score_bcd = s;
      rom_mode  = 1'($urandom_range(0, 1));
      do_line(0, 99);
      do_line(int'($urandom_range(1, 30)), 99);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
